// File: rtl/rdata_s2mm_packer.sv
// ---------------------------------------------------------------------------
// rdata_s2mm_packer
//
// Return path for DRAM read data. Read beats from sddt_core are buffered in a
// first-word-fall-through FIFO and re-emitted as fixed-length AXI-Stream
// packets towards the PS DMA S2MM channel. tlast is raised every PKT_BEATS
// beats. A partial packet is closed early by a flush pulse, or when no new
// beat has arrived for TIMEOUT_CYCLES cycles while data is buffered.
//
// Handshake semantics (both stream ports): a beat transfers on a rising
// clock edge where tvalid && tready. Once this block raises
// M_AXIS_S2MM_tvalid, tdata/tlast stay constant and tvalid stays high until
// that transfer happens. S_AXIS_RDATA_tready depends only on registered
// state and the enable input, never on S_AXIS_RDATA_tvalid.
//
// Ports
//   axi_aclk, axi_aresetn      clock, asynchronous active-low reset
//   S_AXIS_RDATA_*             read-data input stream (tdata/tvalid/tready)
//   M_AXIS_S2MM_*              packetised output stream
//                              (tdata/tkeep/tlast/tvalid/tready)
//   enable                     accept input beats when 1
//   flush                      one-cycle pulse: close the current partial
//                              packet
//   fifo_level                 number of beats held in the FIFO (the output
//                              register is not included)
//   beat_count                 output beats transferred (wraps at 2^32)
//   pkt_count                  output packets transferred (wraps at 2^32)
//   idle                       nothing buffered, nothing in flight, and no
//                              packet partially sent
// ---------------------------------------------------------------------------
module rdata_s2mm_packer #(
    parameter int DATA_WIDTH     = 512,
    parameter int FIFO_DEPTH     = 16,
    parameter int PKT_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,

    input  logic [DATA_WIDTH-1:0]         S_AXIS_RDATA_tdata,
    input  logic                          S_AXIS_RDATA_tvalid,
    output logic                          S_AXIS_RDATA_tready,

    output logic [DATA_WIDTH-1:0]         M_AXIS_S2MM_tdata,
    output logic [DATA_WIDTH/8-1:0]       M_AXIS_S2MM_tkeep,
    output logic                          M_AXIS_S2MM_tlast,
    output logic                          M_AXIS_S2MM_tvalid,
    input  logic                          M_AXIS_S2MM_tready,

    input  logic                          enable,
    input  logic                          flush,

    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   beat_count,
    output logic [31:0]                   pkt_count,
    output logic                          idle
);

    // -----------------------------------------------------------------------
    // Derived widths and constants
    // -----------------------------------------------------------------------
    localparam int AW = $clog2(FIFO_DEPTH);      // FIFO pointer width
    localparam int LW = AW + 1;                  // level width (0..DEPTH)
    localparam int BW = $clog2(PKT_BEATS);       // beat index width
    localparam int TW = $clog2(TIMEOUT_CYCLES);  // idle counter width

    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_TWO  = LW'(2);
    localparam logic [BW-1:0] IDX_LAST = BW'(PKT_BEATS - 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level;

    logic [BW-1:0]         beat_idx;       // position of the next loaded beat
    logic [TW-1:0]         idle_cnt;       // cycles without a push while buffered
    logic                  close_pending;  // close the packet at the last buffered beat

    logic                  out_valid;
    logic                  out_last;
    logic [DATA_WIDTH-1:0] out_data;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic in_ready;
    logic push;
    logic out_fire;
    logic out_free;
    logic head_at_idx_last;
    logic head_eligible;
    logic load;
    logic load_last;
    logic timeout_hit;
    logic flush_hit;

    // Readiness comes from the registered level only; a pop in the same cycle
    // does not open a slot for a push. Held low throughout reset.
    assign in_ready = axi_aresetn && enable && (level < LVL_FULL);
    assign push     = S_AXIS_RDATA_tvalid && in_ready;

    assign out_fire = out_valid && M_AXIS_S2MM_tready;
    assign out_free = !out_valid || out_fire;

    // A non-last beat may leave the FIFO only when a successor is already
    // buffered; that is what lets out_last be decided at load time. The head
    // is also released alone when it is known to end the packet: either it
    // is the final beat of a full packet, or a close has been requested.
    assign head_at_idx_last = (beat_idx == IDX_LAST);
    assign head_eligible    = (level != '0) &&
                              (head_at_idx_last || (level >= LVL_TWO) || close_pending);

    assign load      = out_free && head_eligible;
    assign load_last = head_at_idx_last || (close_pending && (level == LVL_ONE));

    // The level guard keeps a stale count (level just drained to zero) from
    // arming a close with nothing left to close.
    assign timeout_hit = (idle_cnt == IDLE_MAX) && (level != '0);

    // A flush only means something when data exists somewhere downstream of
    // the input; otherwise it is dropped so no empty packet can result.
    assign flush_hit = flush && ((level != '0) || out_valid);

    // -----------------------------------------------------------------------
    // FIFO storage (contents are intentionally not reset)
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk) begin
        if (push) begin
            mem[wr_ptr] <= S_AXIS_RDATA_tdata;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and level
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leave the level unchanged.
            case ({push, load})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output register: loads pop the FIFO head, and the beat is held until
    // the DMA takes it.
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_last  <= load_last;
                out_data  <= mem[rd_ptr];
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Packet framing: beat position and close request
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            beat_idx      <= '0;
            close_pending <= 1'b0;
        end else begin
            if (load) begin
                beat_idx <= load_last ? '0 : beat_idx + BW'(1);
            end

            if (load && load_last) begin
                // The closing beat just left. A flush in this same cycle
                // carries over only if beats remain after this pop.
                close_pending <= flush && (level > LVL_ONE);
            end else if (flush_hit || timeout_hit) begin
                close_pending <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Input-idle counter: counts cycles without a push while data is
    // buffered, saturating at the timeout threshold.
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            idle_cnt <= '0;
        end else begin
            if (push || (level == '0)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transfer counters
    // -----------------------------------------------------------------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (out_fire) begin
                beat_count <= beat_count + 32'd1;
                if (out_last) begin
                    pkt_count <= pkt_count + 32'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign S_AXIS_RDATA_tready = in_ready;

    assign M_AXIS_S2MM_tdata  = out_data;
    assign M_AXIS_S2MM_tkeep  = '1;
    assign M_AXIS_S2MM_tlast  = out_last;
    assign M_AXIS_S2MM_tvalid = out_valid;

    assign fifo_level = level;
    assign idle       = (level == '0) && !out_valid && (beat_idx == '0);

endmodule
